// File: rtl/param_cpu.sv
// param_cpu: small accumulator CPU with a writable instruction memory.
// Latency: every instruction takes 2 cycles (FETCH + EXEC). OUT adds at least one OUT_WAIT cycle.
// Backpressure: OUT holds out_data/out_valid and the PC until out_valid && out_ready.
//
// Optional feature macro: PARAM_CPU_COND_JUMP_EN
//   defined   -> SUB, JZ, JC and the Z/C flags are implemented
//   undefined -> opcodes 6/7/8 behave as NOP and the flags do not exist
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  begin execution at pc=0 (only honoured in IDLE)
//   prog_we/addr/data      instruction memory write port (only honoured in IDLE)
//   out_data/out_valid     value emitted by OUT, with valid
//   out_ready              consumer accepts out_data
//   busy                   high in every state except IDLE
//   pc_dbg                 current program counter
module param_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [4+DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [ADDR_W-1:0]   pc_dbg
);

  localparam int INSTR_W = 4 + DATA_W;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
`ifdef PARAM_CPU_COND_JUMP_EN
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    EXEC     = 2'd2,
    OUT_WAIT = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic [INSTR_W-1:0]  imem [DEPTH];

  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jump_tgt;

  assign opcode   = ir[INSTR_W-1:DATA_W];
  assign operand  = ir[DATA_W-1:0];
  // Natural ADDR_W-bit overflow gives the wrap from the last address to 0.
  assign pc_inc   = pc + ADDR_W'(1);
  // Upper operand bits are ignored for jump targets.
  assign jump_tgt = operand[ADDR_W-1:0];
  assign pc_dbg   = pc;

`ifdef PARAM_CPU_COND_JUMP_EN
  logic              flag_z;
  logic              flag_c;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_diff;

  // Extra MSB carries the carry-out (ADD) or the borrow (SUB).
  assign add_sum  = {1'b0, reg_a} + {1'b0, reg_b};
  assign sub_diff = {1'b0, reg_a} - {1'b0, reg_b};
`endif

  // Instruction memory has no reset so a program survives reset_n.
  // Writes are accepted only while idle; the FETCH after a same-cycle
  // start reads one edge later and therefore sees the new word.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE)) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef PARAM_CPU_COND_JUMP_EN
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          ir    <= imem[pc];
          state <= EXEC;
        end

        EXEC: begin
          // Defaults: advance to the next instruction.
          state <= FETCH;
          pc    <= pc_inc;
          case (opcode)
            OP_LDA: begin
              reg_a  <= operand;
`ifdef PARAM_CPU_COND_JUMP_EN
              flag_z <= (operand == '0);
`endif
            end
            OP_LDB: reg_b <= operand;
            OP_ADD: begin
`ifdef PARAM_CPU_COND_JUMP_EN
              reg_a  <= add_sum[DATA_W-1:0];
              flag_c <= add_sum[DATA_W];
              flag_z <= (add_sum[DATA_W-1:0] == '0);
`else
              reg_a  <= reg_a + reg_b;
`endif
            end
            OP_JMP: pc <= jump_tgt;
            OP_OUT: begin
              // PC advances only once the consumer takes the value.
              out_data  <= reg_a;
              out_valid <= 1'b1;
              pc        <= pc;
              state     <= OUT_WAIT;
            end
`ifdef PARAM_CPU_COND_JUMP_EN
            OP_SUB: begin
              reg_a  <= sub_diff[DATA_W-1:0];
              flag_c <= sub_diff[DATA_W];
              flag_z <= (sub_diff[DATA_W-1:0] == '0);
            end
            OP_JZ: if (flag_z) pc <= jump_tgt;
            OP_JC: if (flag_c) pc <= jump_tgt;
`endif
            OP_HALT: begin
              pc    <= pc;
              state <= IDLE;
              busy  <= 1'b0;
            end
            default: ; // NOP and unused opcodes
          endcase
        end

        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc_inc;
            state     <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// tb_param_cpu: directed-vector bench for param_cpu (DATA_W=8, ADDR_W=4).
// Latency: n/a (testbench).
// Backpressure: drives out_ready low in selected phases to exercise OUT_WAIT.
module tb_param_cpu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [3:0]  pc_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] outs[$];
  int cyc;

  param_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] opd);
    return {op, opd};
  endfunction

  function automatic logic [7:0] first_out();
    if (outs.size() > 0) return outs[0];
    return 8'hxx;
  endfunction

  task automatic load(input logic [3:0] a, input logic [11:0] w);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = w;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Pulse start, optionally writing imem[0] in the same cycle, optionally
  // attempting writes (HALT into addresses 4 and 7) while busy. Records
  // every handshaken output and the number of busy cycles.
  task automatic run(input bit poison, input bit co_write, input logic [11:0] co_word,
                     output int cycles);
    outs.delete();
    cycles = 0;
    @(negedge clk);
    start = 1'b1;
    if (co_write) begin
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = co_word;
    end
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    while (busy && cycles < 200) begin
      if (out_valid && out_ready) outs.push_back(out_data);
      if (poison && cycles < 2) begin
        prog_we   = 1'b1;
        prog_addr = (cycles == 0) ? 4'd4 : 4'd7;
        prog_data = ins(4'hF, 8'h00);
      end else begin
        prog_we = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    prog_we = 1'b0;
    check("run_terminates", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc",        {28'd0, pc_dbg},    32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // LDA 10, LDB 1, ADD, OUT, HALT -> 11.
    // Busy cycles: 5 instructions x 2 + one OUT_WAIT cycle = 11.
    load(4'd0, ins(4'h1, 8'd10));
    load(4'd1, ins(4'h2, 8'd1));
    load(4'd2, ins(4'h3, 8'd0));
    load(4'd3, ins(4'h5, 8'd0));
    load(4'd4, ins(4'hF, 8'd0));
    run(1'b0, 1'b0, 12'h0, cyc);
    check("t1_out_count", outs.size(), 32'd1);
    check("t1_out_data",  {24'd0, first_out()}, 32'd11);
    check("t1_cycles",    cyc, 32'd11);
    check("t1_halt_pc",   {28'd0, pc_dbg}, 32'd4);

    // 200+100 overflows: carry set, 8-bit sum 44.
    load(4'd0, ins(4'h1, 8'd200));
    load(4'd1, ins(4'h2, 8'd100));
    load(4'd2, ins(4'h3, 8'd0));
    load(4'd3, ins(4'h8, 8'd6));
    load(4'd4, ins(4'h5, 8'd0));
    load(4'd5, ins(4'hF, 8'd0));
    load(4'd6, ins(4'h1, 8'd7));
    load(4'd7, ins(4'h5, 8'd0));
    load(4'd8, ins(4'hF, 8'd0));
    run(1'b0, 1'b0, 12'h0, cyc);
    check("t2_out_count", outs.size(), 32'd1);
`ifdef PARAM_CPU_COND_JUMP_EN
    check("t2_out_data",  {24'd0, first_out()}, 32'd7);
    check("t2_halt_pc",   {28'd0, pc_dbg}, 32'd8);
`else
    check("t2_out_data",  {24'd0, first_out()}, 32'd44);
    check("t2_halt_pc",   {28'd0, pc_dbg}, 32'd5);
`endif

    // OUT under backpressure: LDA 0x5A, OUT, HALT
    load(4'd0, ins(4'h1, 8'h5A));
    load(4'd1, ins(4'h5, 8'd0));
    load(4'd2, ins(4'hF, 8'd0));
    out_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_data",  {24'd0, out_data},  32'h5A);
      check("t3_hold_pc",    {28'd0, pc_dbg},    32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t3_pc_advance", {28'd0, pc_dbg},    32'd2);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("t3_idle",       {31'd0, busy},      32'd0);
    check("t3_halt_pc",    {28'd0, pc_dbg},    32'd2);

    // Reset during OUT_WAIT abandons the output; program survives.
    load(4'd0, ins(4'h1, 8'h33));
    out_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("t5_pending",    {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid",  {31'd0, out_valid}, 32'd0);
    check("t5_rst_busy",   {31'd0, busy},      32'd0);
    check("t5_rst_pc",     {28'd0, pc_dbg},    32'd0);
    check("t5_rst_data",   {24'd0, out_data},  32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    run(1'b0, 1'b0, 12'h0, cyc);
    check("t5_rerun_count", outs.size(), 32'd1);
    check("t5_rerun_data",  {24'd0, first_out()}, 32'h33);

    // Writes while busy are dropped; SUB/JZ path.
    load(4'd0, ins(4'h1, 8'd5));
    load(4'd1, ins(4'h2, 8'd5));
    load(4'd2, ins(4'h6, 8'd0));
    load(4'd3, ins(4'h7, 8'd6));
    load(4'd4, ins(4'h5, 8'd0));
    load(4'd5, ins(4'hF, 8'd0));
    load(4'd6, ins(4'h1, 8'h42));
    load(4'd7, ins(4'h5, 8'd0));
    load(4'd8, ins(4'hF, 8'd0));
    run(1'b1, 1'b0, 12'h0, cyc);
    check("t6_out_count", outs.size(), 32'd1);
`ifdef PARAM_CPU_COND_JUMP_EN
    check("t6_out_data",  {24'd0, first_out()}, 32'h42);
    check("t6_halt_pc",   {28'd0, pc_dbg}, 32'd8);
`else
    check("t6_out_data",  {24'd0, first_out()}, 32'd5);
    check("t6_halt_pc",   {28'd0, pc_dbg}, 32'd5);
`endif

    // Write imem[0] in the same cycle as start: LDA 9 is what executes.
    run(1'b0, 1'b1, ins(4'h1, 8'd9), cyc);
    check("t7_out_count", outs.size(), 32'd1);
`ifdef PARAM_CPU_COND_JUMP_EN
    check("t7_out_data",  {24'd0, first_out()}, 32'd4);
`else
    check("t7_out_data",  {24'd0, first_out()}, 32'd9);
`endif
    check("t7_halt_pc",   {28'd0, pc_dbg}, 32'd5);

    // JMP 0xFF -> pc 15 (upper bits ignored), NOP at 15, wrap to 0.
    load(4'd0,  ins(4'h1, 8'd9));
    load(4'd1,  ins(4'h4, 8'hFF));
    load(4'd15, ins(4'h0, 8'd0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      logic [3:0] exp_pc [7];
      exp_pc = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd15, 4'd0};
      for (int i = 0; i < 7; i++) begin
        check($sformatf("t4_pc_seq%0d", i), {28'd0, pc_dbg}, {28'd0, exp_pc[i]});
        @(negedge clk);
      end
    end
    reset_n = 1'b0;
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
